align_acc_norm: RTL

ALIGN_ACC_NORM -- requirements
Module: align_acc_norm

---
 rtl/align_acc_norm_if.sv | 22 ++
 rtl/align_acc_norm.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/align_acc_norm_if.sv
// Operand/result bundle for align_acc_norm: lane arrays in, one IEEE-754 single out.
interface align_acc_norm_if;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  max_exp;
    logic [9:0]  diff [10];
    logic [47:0] mant [10];
    logic [9:0]  sign;       // bit i is lane i, 1 = negative
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;

    modport master (
        output in_valid, max_exp, diff, mant, sign, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, max_exp, diff, mant, sign, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/align_acc_norm.sv
// Ten-lane align/accumulate of product mantissas against a common exponent,
// normalised and packed as an IEEE-754 single (truncating, flush-to-zero).
module align_acc_norm (
    input  logic           clk,
    input  logic           rst_n,
    align_acc_norm_if.slave bus
);

    localparam int unsigned NumLanes = 10;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAcc  = 2'd1;
    localparam logic [1:0] StNorm = 2'd2;
    localparam logic [1:0] StOut  = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [3:0]          lane_q, lane_d;
    logic [55:0]         acc_q, acc_d;
    logic [9:0]          max_exp_q, max_exp_d;
    logic [9:0]          diff_q [NumLanes];
    logic [9:0]          diff_d [NumLanes];
    logic [47:0]         mant_q [NumLanes];
    logic [47:0]         mant_d [NumLanes];
    logic [NumLanes-1:0] sign_q, sign_d;
    logic                out_valid_q, out_valid_d;
    logic [31:0]         out_data_q, out_data_d;

    // Current lane selection and alignment
    logic [47:0] lane_mant;
    logic [9:0]  lane_diff;
    logic        lane_sign;
    logic [55:0] aligned;

    always_comb begin
        lane_mant = '0;
        lane_diff = '0;
        lane_sign = 1'b0;
        for (int i = 0; i < NumLanes; i++) begin
            if (lane_q == i[3:0]) begin
                lane_mant = mant_q[i];
                lane_diff = diff_q[i];
                lane_sign = sign_q[i];
            end
        end
        aligned = (lane_diff >= 10'd48) ? 56'd0 : ({8'd0, lane_mant} >> lane_diff);
    end

    // Normalisation of the two's-complement accumulator
    logic              acc_s;
    logic [55:0]       mag;
    logic [5:0]        lead;
    logic [11:0]       exp_u;
    logic signed [11:0] exp_c;
    logic [22:0]       frac;
    logic [31:0]       norm_word;

    always_comb begin
        acc_s = acc_q[55];
        mag   = acc_s ? (~acc_q + 56'd1) : acc_q;
        lead  = '0;
        for (int i = 0; i < 56; i++) begin
            if (mag[i]) lead = i[5:0];
        end
        frac = '0;
        for (int j = 0; j < 23; j++) begin
            if (int'(lead) - 1 - j >= 0) frac[22-j] = mag[int'(lead) - 1 - j];
        end
        exp_u = {{2{max_exp_q[9]}}, max_exp_q} + {6'd0, lead} - 12'd46;
        exp_c = signed'(exp_u);
        if (acc_q == 56'd0) begin
            norm_word = 32'h0000_0000;
        end else if (exp_c >= 12'sd255) begin
            norm_word = {acc_s, 8'hFF, 23'h0};
        end else if (exp_c <= 12'sd0) begin
            norm_word = {acc_s, 31'h0};
        end else begin
            norm_word = {acc_s, exp_c[7:0], frac};
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

    always_comb begin
        state_d     = state_q;
        lane_d      = lane_q;
        acc_d       = acc_q;
        max_exp_d   = max_exp_q;
        diff_d      = diff_q;
        mant_d      = mant_q;
        sign_d      = sign_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    max_exp_d = bus.max_exp;
                    diff_d    = bus.diff;
                    mant_d    = bus.mant;
                    sign_d    = bus.sign;
                    acc_d     = '0;
                    lane_d    = '0;
                    state_d   = StAcc;
                end
            end
            StAcc: begin
                acc_d = lane_sign ? (acc_q - aligned) : (acc_q + aligned);
                if (lane_q == 4'd9) begin
                    state_d = StNorm;
                end else begin
                    lane_d = lane_q + 4'd1;
                end
            end
            StNorm: begin
                out_data_d = norm_word;
                state_d    = StOut;
            end
            StOut: begin
                // out_valid rises one cycle after out_data settles, then holds for the handshake
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lane_q      <= '0;
            acc_q       <= '0;
            max_exp_q   <= '0;
            sign_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            for (int i = 0; i < NumLanes; i++) begin
                diff_q[i] <= '0;
                mant_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            acc_q       <= acc_d;
            max_exp_q   <= max_exp_d;
            sign_q      <= sign_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            for (int i = 0; i < NumLanes; i++) begin
                diff_q[i] <= diff_d[i];
                mant_q[i] <= mant_d[i];
            end
        end
    end

endmodule
